// File: rtl/fft_stage_sequencer.sv
// Issue sequencer for an in-place radix-2 FFT: walks every butterfly pair of
// every stage, with a drain gap between stages and a delayed write-back strobe.
module fft_stage_sequencer #(
  parameter int N          = 1024,
  parameter int PIPE_DEPTH = 4,
  localparam int LOG2N     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic [LOG2N-1:0] stage,
  output logic [LOG2N-2:0] pair_id,
  output logic             issue_valid,
  output logic             issue_last,
  output logic             wb_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [LOG2N-2:0] PAIR_LAST  = (LOG2N-1)'(N/2 - 1);
  localparam logic [LOG2N-2:0] PAIR_ONE   = (LOG2N-1)'(1);
  localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] STAGE_ONE  = LOG2N'(1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       drain_cnt;
  logic [PIPE_DEPTH-1:0]  wb_vld_p;

  assign issue_valid = (state == S_RUN) & ~stall;
  assign issue_last  = issue_valid & (pair_id == PAIR_LAST);
  assign wb_valid    = wb_vld_p[PIPE_DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stage     <= '0;
      pair_id   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= S_RUN;
            stage   <= '0;
            pair_id <= '0;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (pair_id == PAIR_LAST) begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              pair_id <= pair_id + PAIR_ONE;
            end
          end
        end
        // Drain lasts PIPE_DEPTH cycles so the last write-back of this stage
        // lands before the next stage's first read.
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            if (stage == STAGE_LAST) begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= S_RUN;
              stage   <= stage + STAGE_ONE;
              pair_id <= '0;
            end
          end else begin
            drain_cnt <= drain_cnt - CNT_ONE;
          end
        end
        S_FIN: begin
          state   <= S_IDLE;
          done    <= 1'b0;
          stage   <= '0;
          pair_id <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back strobe: issue_valid delayed exactly PIPE_DEPTH cycles.
  generate
    if (PIPE_DEPTH == 1) begin : g_wb1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) wb_vld_p <= '0;
        else     wb_vld_p <= issue_valid;
      end
    end else begin : g_wbn
      always_ff @(posedge clk or posedge rst) begin
        if (rst) wb_vld_p <= '0;
        else     wb_vld_p <= {wb_vld_p[PIPE_DEPTH-2:0], issue_valid};
      end
    end
  endgenerate

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: small (N=8) and full-size (N=1024) instances
// checked against a timeline model of the transform.
module tb_fft_stage_sequencer;

  localparam int NA = 8, PDA = 2, LA = $clog2(NA);
  localparam int NB = 1024, PDB = 4, LB = $clog2(NB);

  logic clk = 1'b0;
  logic rst;
  logic a_start, a_stall, b_start, b_stall;
  logic [LA-1:0] a_stage;
  logic [LA-2:0] a_pair;
  logic a_iv, a_last, a_wb, a_busy, a_done;
  logic [LB-1:0] b_stage;
  logic [LB-2:0] b_pair;
  logic b_iv, b_last, b_wb, b_busy, b_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.N(NA), .PIPE_DEPTH(PDA)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .stall(a_stall),
    .stage(a_stage), .pair_id(a_pair), .issue_valid(a_iv), .issue_last(a_last),
    .wb_valid(a_wb), .busy(a_busy), .done(a_done));

  fft_stage_sequencer #(.N(NB), .PIPE_DEPTH(PDB)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stall(b_stall),
    .stage(b_stage), .pair_id(b_pair), .issue_valid(b_iv), .issue_last(b_last),
    .wb_valid(b_wb), .busy(b_busy), .done(b_done));

  // te = number of non-stalled cycles since the start edge; each stage is
  // N/2 issue slots followed by PIPE_DEPTH drain slots, then one done slot.
  function automatic void model(input int n, input int pd, input int te,
                                output bit in_run, output int stg, output int pr,
                                output bit bsy, output bit dn);
    int logn, per, tot;
    logn = $clog2(n);
    per  = n/2 + pd;
    tot  = logn * per;
    in_run = 0; stg = 0; pr = 0; bsy = 0; dn = 0;
    if (te < tot) begin
      stg    = te / per;
      in_run = (te % per) < n/2;
      pr     = in_run ? te % per : n/2 - 1;
      bsy    = 1;
    end else if (te == tot) begin
      dn  = 1;
      stg = logn - 1;
      pr  = n/2 - 1;
    end
  endfunction

  // stall_mode: 0 none, 1 window [slo,shi], 2 only outside issue slots, 3 random.
  // start_mode: 0 single pulse, 1 held until done, 2 random while active.
  task automatic run_a(input string tag, input int stall_mode, input int slo, input int shi,
                       input int start_mode, input int exp_done_cyc);
    int te, c, tot, stg, pr, extra, done_seen;
    bit inr, bsy, dn, exp_iv, exp_last, exp_wb;
    bit hist[$];
    tot = LA * (NA/2 + PDA);
    @(posedge clk); #1 a_start = 1; a_stall = 0;
    @(posedge clk);
    te = 0; c = 1; extra = 0; done_seen = -1;
    while ((te <= tot || extra < 3) && c < 400) begin
      #1;
      model(NA, PDA, te, inr, stg, pr, bsy, dn);
      case (stall_mode)
        1:       a_stall = (c >= slo) && (c <= shi);
        2:       a_stall = !inr;
        3:       a_stall = ($urandom % 3) == 0;
        default: a_stall = 0;
      endcase
      if (te <= tot)
        a_start = (start_mode == 1) ? 1'b1 : (start_mode == 2) ? 1'($urandom % 2) : 1'b0;
      else
        a_start = 0;
      exp_iv   = inr && !a_stall;
      exp_last = exp_iv && (pr == NA/2 - 1);
      exp_wb   = (hist.size() >= PDA) ? hist[hist.size() - PDA] : 1'b0;
      @(negedge clk);
      n_cmp++; if (a_iv !== exp_iv) begin n_bad++;
        $display("FAIL %s c%0d issue_valid got %b want %b", tag, c, a_iv, exp_iv); end
      n_cmp++; if (a_last !== exp_last) begin n_bad++;
        $display("FAIL %s c%0d issue_last got %b want %b", tag, c, a_last, exp_last); end
      n_cmp++; if (a_stage !== LA'(stg)) begin n_bad++;
        $display("FAIL %s c%0d stage got %0d want %0d", tag, c, a_stage, stg); end
      n_cmp++; if (a_pair !== (LA-1)'(pr)) begin n_bad++;
        $display("FAIL %s c%0d pair_id got %0d want %0d", tag, c, a_pair, pr); end
      n_cmp++; if (a_busy !== bsy) begin n_bad++;
        $display("FAIL %s c%0d busy got %b want %b", tag, c, a_busy, bsy); end
      n_cmp++; if (a_done !== dn) begin n_bad++;
        $display("FAIL %s c%0d done got %b want %b", tag, c, a_done, dn); end
      n_cmp++; if (a_wb !== exp_wb) begin n_bad++;
        $display("FAIL %s c%0d wb_valid got %b want %b", tag, c, a_wb, exp_wb); end
      if (a_done === 1'b1 && done_seen < 0) done_seen = c;
      hist.push_back(exp_iv);
      if (te > tot) extra++;
      else if (!(inr && a_stall)) te++;
      c++;
      @(posedge clk);
    end
    #1 a_start = 0; a_stall = 0;
    n_cmp++; if (c >= 400) begin n_bad++;
      $display("FAIL %s timeout cycles got %0d want <400", tag, c); end
    if (exp_done_cyc > 0) begin
      n_cmp++; if (done_seen != exp_done_cyc) begin n_bad++;
        $display("FAIL %s done_cycle got %0d want %0d", tag, done_seen, exp_done_cyc); end
    end
  endtask

  task automatic test_reset();
    rst = 1; a_start = 0; a_stall = 0; b_start = 0; b_stall = 0;
    repeat (2) @(posedge clk);
    a_start = 1; b_start = 1;
    @(negedge clk);
    n_cmp++; if ({a_iv, a_last, a_wb, a_busy, a_done} !== 5'b0) begin n_bad++;
      $display("FAIL reset a_flags got %b want 00000", {a_iv, a_last, a_wb, a_busy, a_done}); end
    n_cmp++; if ({a_stage, a_pair} !== '0) begin n_bad++;
      $display("FAIL reset a_stage_pair got %0d/%0d want 0/0", a_stage, a_pair); end
    n_cmp++; if ({b_iv, b_last, b_wb, b_busy, b_done} !== 5'b0) begin n_bad++;
      $display("FAIL reset b_flags got %b want 00000", {b_iv, b_last, b_wb, b_busy, b_done}); end
    n_cmp++; if ({b_stage, b_pair} !== '0) begin n_bad++;
      $display("FAIL reset b_stage_pair got %0d/%0d want 0/0", b_stage, b_pair); end
    @(posedge clk); #1 a_start = 0; b_start = 0; rst = 0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if ({a_iv, a_busy, a_done, a_wb, b_iv, b_busy, b_done, b_wb} !== 8'b0) begin n_bad++;
        $display("FAIL post_reset_idle got %b want 00000000",
                 {a_iv, a_busy, a_done, a_wb, b_iv, b_busy, b_done, b_wb}); end
    end
  endtask

  task automatic test_nominal();
    run_a("nominal", 0, 0, 0, 0, 19);
  endtask

  task automatic test_stall();
    run_a("stall_run", 1, 2, 3, 0, 21);
  endtask

  task automatic test_drain_stall();
    run_a("stall_drain", 2, 0, 0, 0, 19);
  endtask

  task automatic test_start_hold();
    run_a("start_hold", 0, 0, 0, 1, 19);
    run_a("restart", 0, 0, 0, 0, 19);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 a_start = 1;
    @(posedge clk); #1 a_start = 0;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if ({a_iv, a_wb, a_stage} !== {2'b11, LA'(1)}) begin n_bad++;
      $display("FAIL mid_pre_reset iv/wb/stage got %b/%b/%0d want 1/1/1", a_iv, a_wb, a_stage); end
    #2 rst = 1;
    #1;
    n_cmp++; if ({a_iv, a_last, a_wb, a_busy, a_done} !== 5'b0) begin n_bad++;
      $display("FAIL mid_reset flags got %b want 00000", {a_iv, a_last, a_wb, a_busy, a_done}); end
    n_cmp++; if ({a_stage, a_pair} !== '0) begin n_bad++;
      $display("FAIL mid_reset stage_pair got %0d/%0d want 0/0", a_stage, a_pair); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if ({a_iv, a_wb, a_busy, a_done} !== 4'b0) begin n_bad++;
        $display("FAIL after_abort c%0d iv/wb/busy/done got %b want 0000", i, {a_iv, a_wb, a_busy, a_done}); end
    end
    run_a("after_abort", 0, 0, 0, 0, 19);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) run_a("random", 3, 0, 0, 2, -1);
  endtask

  task automatic test_large();
    int iv_cnt, wb_cnt, last_cnt, done_cnt, done_cyc;
    iv_cnt = 0; wb_cnt = 0; last_cnt = 0; done_cnt = 0; done_cyc = -1;
    @(posedge clk); #1 b_start = 1;
    @(posedge clk); #1 b_start = 0;
    for (int c = 1; c <= 5175; c++) begin
      @(negedge clk);
      if (b_wb === 1'b1) wb_cnt++;
      if (b_iv === 1'b1) begin
        iv_cnt++;
        if (b_pair == 0 && b_stage != 0) begin
          n_cmp++; if (wb_cnt != int'(b_stage) * (NB/2)) begin n_bad++;
            $display("FAIL large_wb_before_stage%0d got %0d want %0d", b_stage, wb_cnt, int'(b_stage) * (NB/2)); end
        end
      end
      if (b_last === 1'b1) last_cnt++;
      if (b_done === 1'b1) begin done_cnt++; done_cyc = c; end
    end
    n_cmp++; if (iv_cnt != LB * NB/2) begin n_bad++;
      $display("FAIL large_issue_count got %0d want %0d", iv_cnt, LB * NB/2); end
    n_cmp++; if (wb_cnt != LB * NB/2) begin n_bad++;
      $display("FAIL large_wb_count got %0d want %0d", wb_cnt, LB * NB/2); end
    n_cmp++; if (last_cnt != LB) begin n_bad++;
      $display("FAIL large_last_count got %0d want %0d", last_cnt, LB); end
    n_cmp++; if (done_cnt != 1) begin n_bad++;
      $display("FAIL large_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc != 1 + LB * (NB/2 + PDB)) begin n_bad++;
      $display("FAIL large_done_cycle got %0d want %0d", done_cyc, 1 + LB * (NB/2 + PDB)); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_drain_stall();
    test_start_hold();
    test_reset_mid();
    test_random();
    test_large();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
